// File: rtl/ex_pkg.sv
// Shared opcode, forwarding-select and multi-cycle helper definitions for the execute stage.
package ex_pkg;

   localparam int OP_W = 5;

   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 5'd0,
      OP_SUB   = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_XOR   = 5'd4,
      OP_NOR   = 5'd5,
      OP_SLT   = 5'd6,
      OP_SLTU  = 5'd7,
      OP_SLL   = 5'd8,
      OP_SRL   = 5'd9,
      OP_SRA   = 5'd10,
      OP_LUI   = 5'd11,
      OP_MUL   = 5'd12,
      OP_MULHU = 5'd13,
      OP_DIVU  = 5'd14,
      OP_REMU  = 5'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_MUL   = 2'd0,
      MD_MULHU = 2'd1,
      MD_DIVU  = 2'd2,
      MD_REMU  = 2'd3
   } md_op_e;

   localparam logic [2:0] FWD_ID_EX  = 3'b001;
   localparam logic [2:0] FWD_EX_MEM = 3'b010;
   localparam logic [2:0] FWD_MEM_WB = 3'b100;

   function automatic logic is_multicycle(input alu_op_e op);
      return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
   endfunction

   function automatic md_op_e to_md_op(input alu_op_e op);
      md_op_e md;
      case (op)
         OP_MULHU: md = MD_MULHU;
         OP_DIVU:  md = MD_DIVU;
         OP_REMU:  md = MD_REMU;
         default:  md = MD_MUL;
      endcase
      return md;
   endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle for XLEN cycles.
// The hi/lo pair holds the 2*XLEN product, or remainder/quotient while dividing.
module mul_div_iter
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  md_op_e          op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   logic [CW-1:0]   cnt;
   logic            running;
   md_op_e          op_q;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] b_q;
   logic [XLEN:0]   add_sum;
   logic [XLEN:0]   rem_shift;
   logic [XLEN:0]   rem_diff;
   logic            is_div;

   always_comb begin
      add_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
      rem_shift = {hi, lo[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, b_q};
      is_div    = (op_q == MD_DIVU) || (op_q == MD_REMU);
   end

   // A zero divisor never borrows, so the quotient fills with ones and the dividend shifts into hi.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         running <= 1'b0;
         op_q    <= MD_MUL;
         hi      <= '0;
         lo      <= '0;
         b_q     <= '0;
      end else if (start) begin
         op_q    <= op;
         b_q     <= b;
         hi      <= '0;
         lo      <= a;
         cnt     <= CW'(XLEN - 1);
         running <= 1'b1;
      end else if (running) begin
         if (!is_div) begin
            {hi, lo} <= {add_sum, lo[XLEN-1:1]};
         end else if (!rem_diff[XLEN]) begin
            hi <= rem_diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
         end else begin
            hi <= rem_shift[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b0};
         end
         cnt <= cnt - 1'b1;
         if (cnt == '0) begin
            running <= 1'b0;
         end
      end
   end

   // done marks the final iteration; result is valid from the following cycle on.
   assign done   = running && (cnt == '0);
   assign result = ((op_q == MD_MUL) || (op_q == MD_DIVU)) ? lo : hi;

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: operand forwarding, single-cycle ALU, iterative MUL/DIV and the
// EX/MEM register behind a valid/ready handshake.
module ex_stage_pipe
   import ex_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int OPW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      fwd_a,
   input  logic [2:0]      fwd_b,
   input  logic [XLEN-1:0] id_ex_a,
   input  logic [XLEN-1:0] id_ex_b,
   input  logic [XLEN-1:0] ex_mem_fwd,
   input  logic [XLEN-1:0] mem_wb_fwd,
   input  logic [XLEN-1:0] imm,
   input  logic            alu_src,
   input  logic            reg_dst,
   input  logic [OPW-1:0]  alu_op,
   input  logic [REGW-1:0] rt,
   input  logic [REGW-1:0] rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_zero,
   output logic [XLEN-1:0] out_store_data,
   output logic [REGW-1:0] out_reg_dest,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e          state;
   alu_op_e         op;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb_fwd;
   logic [XLEN-1:0] opb;
   logic [XLEN-1:0] alu_res;
   logic [SHW-1:0]  shamt;
   logic [REGW-1:0] dest;
   logic [REGW-1:0] md_dest;
   logic [XLEN-1:0] md_store;
   logic [XLEN-1:0] md_result;
   logic            md_done;
   logic            multi;
   logic            transfer;

   assign op       = alu_op_e'(OP_W'(alu_op));
   assign multi    = is_multicycle(op);
   assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
   assign transfer = in_valid && in_ready;
   assign dest     = reg_dst ? rd : rt;

   // Any select that is not exactly one-hot falls back to the register-file operand.
   always_comb begin
      case (fwd_a)
         FWD_ID_EX:  opa = id_ex_a;
         FWD_EX_MEM: opa = ex_mem_fwd;
         FWD_MEM_WB: opa = mem_wb_fwd;
         default:    opa = id_ex_a;
      endcase
      case (fwd_b)
         FWD_ID_EX:  opb_fwd = id_ex_b;
         FWD_EX_MEM: opb_fwd = ex_mem_fwd;
         FWD_MEM_WB: opb_fwd = mem_wb_fwd;
         default:    opb_fwd = id_ex_b;
      endcase
      opb   = alu_src ? imm : opb_fwd;
      shamt = opb[SHW-1:0];
   end

   always_comb begin
      case (op)
         OP_ADD:  alu_res = opa + opb;
         OP_SUB:  alu_res = opa - opb;
         OP_AND:  alu_res = opa & opb;
         OP_OR:   alu_res = opa | opb;
         OP_XOR:  alu_res = opa ^ opb;
         OP_NOR:  alu_res = ~(opa | opb);
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
         OP_SLL:  alu_res = opa << shamt;
         OP_SRL:  alu_res = opa >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(opa) >>> shamt);
         OP_LUI:  alu_res = opb << (XLEN / 2);
         default: alu_res = '0;
      endcase
   end

   mul_div_iter #(
      .XLEN (XLEN)
   ) u_mul_div (
      .clk    (clk),
      .rst    (rst),
      .start  (transfer && multi),
      .op     (to_md_op(op)),
      .a      (opa),
      .b      (opb),
      .done   (md_done),
      .result (md_result)
   );

   // Consumption clears out_valid unless the same edge loads a fresh result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         busy           <= 1'b0;
         md_dest        <= '0;
         md_store       <= '0;
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_zero       <= 1'b0;
         out_store_data <= '0;
         out_reg_dest   <= '0;
      end else begin
         if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (transfer) begin
                  if (multi) begin
                     state    <= ((op == OP_MUL) || (op == OP_MULHU)) ? S_MUL : S_DIV;
                     busy     <= 1'b1;
                     md_dest  <= dest;
                     md_store <= opb_fwd;
                  end else begin
                     out_valid      <= 1'b1;
                     out_result     <= alu_res;
                     out_zero       <= (alu_res == '0);
                     out_store_data <= opb_fwd;
                     out_reg_dest   <= dest;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (md_done) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (!out_valid || out_ready) begin
                  out_valid      <= 1'b1;
                  out_result     <= md_result;
                  out_zero       <= (md_result == '0);
                  out_store_data <= md_store;
                  out_reg_dest   <= md_dest;
                  busy           <= 1'b0;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: forwarding, ALU ops, multi-cycle latency, backpressure, reset abort.
module tb_ex_stage_pipe;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  fwd_a;
   logic [2:0]  fwd_b;
   logic [31:0] id_ex_a;
   logic [31:0] id_ex_b;
   logic [31:0] ex_mem_fwd;
   logic [31:0] mem_wb_fwd;
   logic [31:0] imm;
   logic        alu_src;
   logic        reg_dst;
   logic [4:0]  alu_op;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic [31:0] out_store_data;
   logic [4:0]  out_reg_dest;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   ex_stage_pipe #(.XLEN(32), .REGW(5), .OPW(5)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b),
      .id_ex_a        (id_ex_a),
      .id_ex_b        (id_ex_b),
      .ex_mem_fwd     (ex_mem_fwd),
      .mem_wb_fwd     (mem_wb_fwd),
      .imm            (imm),
      .alu_src        (alu_src),
      .reg_dst        (reg_dst),
      .alu_op         (alu_op),
      .rt             (rt),
      .rd             (rd),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_zero       (out_zero),
      .out_store_data (out_store_data),
      .out_reg_dest   (out_reg_dest),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      in_valid   = 1'b0;
      fwd_a      = FWD_ID_EX;
      fwd_b      = FWD_ID_EX;
      id_ex_a    = '0;
      id_ex_b    = '0;
      ex_mem_fwd = '0;
      mem_wb_fwd = '0;
      imm        = '0;
      alu_src    = 1'b0;
      reg_dst    = 1'b1;
      alu_op     = OP_ADD;
      rt         = 5'd4;
      rd         = 5'd9;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      set_defaults();
      tick();
      tick();
      vectors++;
      if (out_valid !== 1'b0 || out_result !== 32'd0 || out_zero !== 1'b0 ||
          out_store_data !== 32'd0 || out_reg_dest !== 5'd0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got v=%b r=%h z=%b s=%h d=%0d busy=%b, expected all zero",
                  out_valid, out_result, out_zero, out_store_data, out_reg_dest, busy);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_forwarding();
      fwd_a = 3'b010; ex_mem_fwd = 32'd7;
      fwd_b = 3'b100; mem_wb_fwd = 32'd5;
      id_ex_a = 32'd100; id_ex_b = 32'd200;
      alu_op = OP_ADD; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_result !== 32'd12 || out_zero !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL fwd_add: got v=%b r=%0d z=%b expected v=1 r=12 z=0", out_valid, out_result, out_zero);
      end
      vectors++;
      if (out_reg_dest !== 5'd9 || out_store_data !== 32'd5) begin
         miscompares++;
         $display("[TB] FAIL fwd_dest_store: got d=%0d s=%0d expected d=9 s=5", out_reg_dest, out_store_data);
      end
      set_defaults();
   endtask

   task automatic test_illegal_fwd();
      fwd_a = 3'b011; id_ex_a = 32'd3; ex_mem_fwd = 32'd50; mem_wb_fwd = 32'd60;
      fwd_b = FWD_ID_EX; id_ex_b = 32'd55;
      alu_src = 1'b1; imm = 32'hFFFF_FFFD; reg_dst = 1'b0;
      alu_op = OP_ADD; in_valid = 1'b1;
      tick();
      vectors++;
      if (out_result !== 32'd0 || out_zero !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL illegal_fwd_add: got r=%h z=%b expected r=0 z=1", out_result, out_zero);
      end
      vectors++;
      if (out_reg_dest !== 5'd4 || out_store_data !== 32'd55) begin
         miscompares++;
         $display("[TB] FAIL illegal_fwd_dest: got d=%0d s=%0d expected d=4 s=55", out_reg_dest, out_store_data);
      end
      fwd_a = 3'b000; fwd_b = 3'b110; alu_src = 1'b0; reg_dst = 1'b1;
      id_ex_a = 32'd10; id_ex_b = 32'd20; alu_op = OP_SUB;
      tick();
      in_valid = 1'b0;
      vectors++;
      if (out_result !== 32'hFFFF_FFF6 || out_store_data !== 32'd20) begin
         miscompares++;
         $display("[TB] FAIL zero_sel_sub: got r=%h s=%0d expected r=fffffff6 s=20", out_result, out_store_data);
      end
      set_defaults();
   endtask

   task automatic test_back_to_back();
      logic [4:0]  ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
                                OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI, 5'd31};
      logic [31:0] av  [13] = '{32'hFFFF_FFFF, 32'd5, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hAAAA_5555,
                                32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                                32'h8000_0000, 32'd0, 32'd7};
      logic [31:0] bv  [13] = '{32'd1, 32'd7, 32'hFF00_FF00, 32'h0F0F_0000, 32'hFFFF_0000,
                                32'd0, 32'd1, 32'd1, 32'h21, 32'd4, 32'd4, 32'h0000_1234, 32'd8};
      logic [31:0] ev  [13] = '{32'd0, 32'hFFFF_FFFE, 32'hF000_F000, 32'hFFFF_F0F0, 32'h5555_5555,
                                32'hFFFF_FFFF, 32'd1, 32'd0, 32'd2, 32'h0800_0000,
                                32'hF800_0000, 32'h1234_0000, 32'd0};
      in_valid = 1'b1;
      for (int i = 0; i < 13; i++) begin
         alu_op = ops[i]; id_ex_a = av[i]; id_ex_b = bv[i];
         tick();
         vectors++;
         if (out_valid !== 1'b1 || out_result !== ev[i] || out_zero !== (ev[i] == 32'd0)) begin
            miscompares++;
            $display("[TB] FAIL alu_op%0d: got v=%b r=%h z=%b expected v=1 r=%h", ops[i], out_valid,
                     out_result, out_zero, ev[i]);
         end
      end
      in_valid = 1'b0;
      set_defaults();
   endtask

   task automatic test_multicycle_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] expected, input string name);
      int stall_bad = 0;
      alu_op = op; id_ex_a = a; id_ex_b = b; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= 32; k++) begin
         if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) stall_bad++;
         if (k < 32) tick();
      end
      vectors++;
      if (stall_bad != 0) begin
         miscompares++;
         $display("[TB] FAIL %s_stall: %0d cycles with wrong valid/ready/busy, expected 0", name, stall_bad);
      end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_result !== expected || out_reg_dest !== 5'd9) begin
         miscompares++;
         $display("[TB] FAIL %s_result: got v=%b r=%h d=%0d expected v=1 r=%h d=9", name, out_valid,
                  out_result, out_reg_dest, expected);
      end
      vectors++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s_idle: got busy=%b ready=%b expected busy=0 ready=1", name, busy, in_ready);
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      int cycles = 0;
      tick();
      out_ready = 1'b0;
      alu_op = OP_ADD; id_ex_a = 32'd1; id_ex_b = 32'd1; in_valid = 1'b1;
      tick();
      alu_op = OP_ADD; id_ex_a = 32'd5; id_ex_b = 32'd5;
      for (int k = 0; k < 3; k++) begin
         if (out_valid !== 1'b1 || out_result !== 32'd2 || in_ready !== 1'b0) bad++;
         tick();
      end
      vectors++;
      if (bad != 0 || out_result !== 32'd2) begin
         miscompares++;
         $display("[TB] FAIL hold_single: %0d bad cycles, r=%0d expected stable r=2 with ready=0", bad, out_result);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL consume_clear: got v=%b expected 0", out_valid);
      end
      out_ready = 1'b0;
      alu_op = OP_DIVU; id_ex_a = 32'd100; id_ex_b = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && cycles < 40) begin
         tick();
         cycles++;
      end
      vectors++;
      if (cycles != 33 || out_result !== 32'd14) begin
         miscompares++;
         $display("[TB] FAIL div_under_stall: got latency=%0d r=%0d expected latency=33 r=14", cycles, out_result);
      end
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (out_valid !== 1'b1 || out_result !== 32'd14 || in_ready !== 1'b0) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("[TB] FAIL hold_div: %0d bad cycles expected 0", bad);
      end
      out_ready = 1'b1;
      tick();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL div_consume: got v=%b ready=%b expected v=0 ready=1", out_valid, in_ready);
      end
      set_defaults();
   endtask

   task automatic test_reset_abort();
      int stale = 0;
      out_ready = 1'b1;
      alu_op = OP_DIVU; id_ex_a = 32'd100; id_ex_b = 32'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      #2;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_in_reset: got v=%b busy=%b expected 0 0", out_valid, busy);
      end
      rst = 1'b0;
      tick();
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL abort_after: got ready=%b busy=%b v=%b expected 1 0 0", in_ready, busy, out_valid);
      end
      for (int k = 0; k < 40; k++) begin
         if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
         tick();
      end
      vectors++;
      if (stale != 0) begin
         miscompares++;
         $display("[TB] FAIL abort_stale: %0d cycles with stale valid/busy expected 0", stale);
      end
      alu_op = OP_ADD; id_ex_a = 32'd2; id_ex_b = 32'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || out_result !== 32'd5) begin
         miscompares++;
         $display("[TB] FAIL abort_recover: got v=%b r=%0d expected v=1 r=5", out_valid, out_result);
      end
      set_defaults();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_illegal_fwd();
      test_back_to_back();
      test_multicycle_op(OP_MUL,   32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFE, "mul");
      test_multicycle_op(OP_MULHU, 32'hFFFF_FFFF, 32'd2,        32'd1,         "mulhu");
      test_multicycle_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
      test_multicycle_op(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        "mul_max");
      test_multicycle_op(OP_DIVU,  32'd100,       32'd0,        32'hFFFF_FFFF, "divu_zero");
      test_multicycle_op(OP_REMU,  32'd100,       32'd0,        32'd100,       "remu_zero");
      test_multicycle_op(OP_DIVU,  32'd100,       32'd7,        32'd14,        "divu");
      test_multicycle_op(OP_REMU,  32'd100,       32'd7,        32'd2,         "remu");
      test_backpressure();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
